// File: rtl/mc_pkg.sv
// ============================================================================
// Module : mc_pkg
// Brief  : Shared state, opcode and ALU-op encodings for the multicycle control FSM.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;

    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] C_SEL_00 = 2'b00;
    localparam logic [1:0] C_SEL_01 = 2'b01;
    localparam logic [1:0] C_SEL_10 = 2'b10;
    localparam logic [1:0] C_SEL_11 = 2'b11;

    // Immediate format follows the instruction class, independent of FSM state.
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        logic [1:0] sel;
        sel = C_SEL_00;
        case (op)
            C_OP_STORE:  sel = C_SEL_01;
            C_OP_BRANCH: sel = C_SEL_10;
            C_OP_JAL:    sel = C_SEL_11;
            default:     sel = C_SEL_00;
        endcase
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_perf_counters.sv
// ============================================================================
// Module : mc_perf_counters
// Brief  : Free-running cycle and retired-instruction counters, instantiated by
//          mc_controller only when MC_CTRL_PERF_EN is defined.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mc_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cycle_en_i,
    input  logic        retire_i,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_cnt_o
);

    logic [31:0] cycle_q;
    logic [31:0] cycle_d;
    logic [31:0] instret_q;
    logic [31:0] instret_d;

    // Both counters wrap naturally at 32 bits.
    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        if (cycle_en_i) begin
            cycle_d = cycle_q + 32'd1;
        end
        if (retire_i) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt_o   = cycle_q;
    assign instret_cnt_o = instret_q;

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// Module : mc_controller
// Brief  : Moore control FSM for a multicycle RV32 datapath. Define
//          MC_CTRL_PERF_EN to add the cycle_cnt / instret_cnt outputs.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_op,
    output logic [1:0]  imm_src,
    output logic        illegal_instr,
    output logic [3:0]  state_o
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    state_t state_q;
    state_t state_d;
    logic   run_q;

    // run_q holds every output quiet until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = C_SEL_00;
        alu_src_b     = C_SEL_00;
        result_src    = C_SEL_00;
        alu_op        = C_ALUOP_ADD;
        illegal_instr = 1'b0;
        imm_src       = run_q ? imm_sel(op) : C_SEL_00;

        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_b  = C_SEL_10;
                        result_src = C_SEL_10;
                        state_d    = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a = C_SEL_01;
                    alu_src_b = C_SEL_01;
                    case (op)
                        C_OP_LOAD, C_OP_STORE: state_d = S_MEMADR;
                        C_OP_RTYPE:            state_d = S_EXECR;
                        C_OP_ITYPE:            state_d = S_EXECI;
                        C_OP_JAL:              state_d = S_JAL;
                        C_OP_BRANCH:           state_d = S_BEQ;
                        default: begin
                            illegal_instr = 1'b1;
                            state_d       = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = C_SEL_10;
                    alu_src_b = C_SEL_01;
                    state_d   = (op == C_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    result_src = C_SEL_01;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                    end
                end
                S_EXECR: begin
                    alu_src_a = C_SEL_10;
                    alu_op    = C_ALUOP_FUNCT;
                    state_d   = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a = C_SEL_10;
                    alu_src_b = C_SEL_01;
                    alu_op    = C_ALUOP_FUNCT;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_JAL: begin
                    alu_src_a = C_SEL_01;
                    alu_src_b = C_SEL_10;
                    pc_write  = 1'b1;
                    state_d   = S_ALUWB;
                end
                S_BEQ: begin
                    alu_src_a = C_SEL_10;
                    alu_op    = C_ALUOP_SUB;
                    pc_write  = zero;
                    state_d   = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign state_o = state_q;

`ifdef MC_CTRL_PERF_EN
    logic retire_w;

    // An illegal DECODE returns to FETCH without retiring anything.
    assign retire_w = run_q && (state_q != S_FETCH) && (state_d == S_FETCH) && !illegal_instr;

    mc_perf_counters u_perf (
        .clk           (clk),
        .rst_n         (rst_n),
        .cycle_en_i    (run_q),
        .retire_i      (retire_w),
        .cycle_cnt_o   (cycle_cnt),
        .instret_cnt_o (instret_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// Module : tb_mc_controller
// Brief  : Scoreboard bench for mc_controller; perf counter checks are active
//          when MC_CTRL_PERF_EN is defined.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mc_controller;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_BAD    = 7'b0000000;
    localparam logic [16:0] ZERO     = 17'd0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  op = 7'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src, alu_op, imm_src;
    logic        illegal_instr;
    logic [3:0]  state_o;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    mc_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .alu_op        (alu_op),
        .imm_src       (imm_src),
        .illegal_instr (illegal_instr),
        .state_o       (state_o)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
`endif
    );

    logic [16:0] act;
    assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, result_src, alu_op, imm_src, illegal_instr};

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] vec;
        logic        perf;
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;

    exp_t  sbq[$];
    string nmq[$];
    int    checks = 0;
    int    failures = 0;

    logic        pend_perf = 1'b0;
    logic [31:0] pend_cyc = 32'd0;
    logic [31:0] pend_ins = 32'd0;

    function automatic logic [16:0] mk(input logic mrq, input logic mw, input logic ad,
                                       input logic ir, input logic pc, input logic rg,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] rs, input logic [1:0] ao,
                                       input logic [1:0] im, input logic il);
        return {mrq, mw, ad, ir, pc, rg, a, b, rs, ao, im, il};
    endfunction

    // Monitor: the controller presents a response every cycle; compare at negedge.
    always @(negedge clk) begin : monitor
        exp_t  e;
        string n;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n = nmq.pop_front();
            checks++;
            if (state_o !== e.st || act !== e.vec) begin
                failures++;
                $display("FAIL %s: got state=%0d out=%b, expected state=%0d out=%b",
                         n, state_o, act, e.st, e.vec);
            end
`ifdef MC_CTRL_PERF_EN
            if (e.perf) begin
                checks++;
                if (cycle_cnt !== e.cyc || instret_cnt !== e.ins) begin
                    failures++;
                    $display("FAIL %s_perf: got cycle=%0d instret=%0d, expected cycle=%0d instret=%0d",
                             n, cycle_cnt, instret_cnt, e.cyc, e.ins);
                end
            end
`endif
        end
    end

    task automatic push_exp(input string n, input logic [3:0] st, input logic [16:0] v);
        sbq.push_back('{st: st, vec: v, perf: pend_perf, cyc: pend_cyc, ins: pend_ins});
        nmq.push_back(n);
        pend_perf = 1'b0;
    endtask

    task automatic expect_perf(input logic [31:0] c, input logic [31:0] i);
        pend_perf = 1'b1;
        pend_cyc  = c;
        pend_ins  = i;
    endtask

    task automatic cyc(input string n, input logic [6:0] o, input logic z, input logic mr,
                       input logic [3:0] st, input logic [16:0] v);
        op        = o;
        zero      = z;
        mem_ready = mr;
        push_exp(n, st, v);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_dec(input string n, input logic [6:0] o, input logic [1:0] im);
        cyc({n, "_fetch"},  o, 1'b0, 1'b1, 4'd0, mk(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b00, im, 0));
        cyc({n, "_decode"}, o, 1'b0, 1'b1, 4'd1, mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, im, 0));
    endtask

    task automatic run_lw(input string n);
        fetch_dec(n, OP_LOAD, 2'b00);
        cyc({n, "_memadr"},  OP_LOAD, 1'b0, 1'b1, 4'd2, mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 2'b00, 0));
        cyc({n, "_memread"}, OP_LOAD, 1'b0, 1'b1, 4'd3, mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 2'b00, 0));
        cyc({n, "_memwb"},   OP_LOAD, 1'b0, 1'b1, 4'd4, mk(0,0,0,0,0,1, 2'b00,2'b00,2'b01,2'b00, 2'b00, 0));
    endtask

    initial begin : stimulus
        @(posedge clk);
        #1;
        // Reset with a store opcode and mem_ready high: nothing may leak out.
        cyc("reset_a", OP_STORE, 1'b0, 1'b1, 4'd0, ZERO);
        cyc("reset_b", OP_STORE, 1'b0, 1'b1, 4'd0, ZERO);
        rst_n = 1'b1;
        cyc("release_idle", OP_STORE, 1'b0, 1'b1, 4'd0, ZERO);

        for (int i = 0; i < 10; i++) begin
            fetch_dec("rtype", OP_RTYPE, 2'b00);
            cyc("rtype_execr", OP_RTYPE, 1'b0, 1'b1, 4'd6, mk(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 2'b00, 0));
            cyc("rtype_aluwb", OP_RTYPE, 1'b0, 1'b1, 4'd7, mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 2'b00, 0));
        end

        expect_perf(32'd40, 32'd10);
        run_lw("lw");

        cyc("sw_fetch_wait", OP_STORE, 1'b0, 1'b0, 4'd0, mk(1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 2'b01, 0));
        fetch_dec("sw", OP_STORE, 2'b01);
        cyc("sw_memadr", OP_STORE, 1'b0, 1'b1, 4'd2, mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 2'b01, 0));
        for (int i = 0; i < 3; i++) begin
            cyc("sw_memwrite_wait", OP_STORE, 1'b0, 1'b0, 4'd5, mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 2'b01, 0));
        end
        cyc("sw_memwrite_done", OP_STORE, 1'b0, 1'b1, 4'd5, mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 2'b01, 0));

        fetch_dec("beq_t", OP_BRANCH, 2'b10);
        cyc("beq_taken", OP_BRANCH, 1'b1, 1'b1, 4'd10, mk(0,0,0,0,1,0, 2'b10,2'b00,2'b00,2'b01, 2'b10, 0));
        fetch_dec("beq_n", OP_BRANCH, 2'b10);
        cyc("beq_not_taken", OP_BRANCH, 1'b0, 1'b1, 4'd10, mk(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b01, 2'b10, 0));

        fetch_dec("jal", OP_JAL, 2'b11);
        cyc("jal_jal",   OP_JAL, 1'b0, 1'b1, 4'd9, mk(0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b00, 2'b11, 0));
        cyc("jal_aluwb", OP_JAL, 1'b0, 1'b1, 4'd7, mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 2'b11, 0));

        fetch_dec("itype", OP_ITYPE, 2'b00);
        cyc("itype_execi", OP_ITYPE, 1'b0, 1'b1, 4'd8, mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b10, 2'b00, 0));
        cyc("itype_aluwb", OP_ITYPE, 1'b0, 1'b1, 4'd7, mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 2'b00, 0));

        expect_perf(32'd67, 32'd16);
        cyc("ill_fetch",  OP_BAD, 1'b0, 1'b1, 4'd0, mk(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b00, 2'b00, 0));
        cyc("ill_decode", OP_BAD, 1'b0, 1'b1, 4'd1, mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 2'b00, 1));

        // Illegal op retires nothing; then drive a load into MEMREAD and reset there.
        expect_perf(32'd69, 32'd16);
        fetch_dec("rst_lw", OP_LOAD, 2'b00);
        cyc("rst_lw_memadr", OP_LOAD, 1'b0, 1'b1, 4'd2, mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 2'b00, 0));
        op        = OP_LOAD;
        mem_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        push_exp("rst_async_memread", 4'd0, ZERO);
        @(posedge clk);
        #1;
        cyc("rst_hold", OP_LOAD, 1'b0, 1'b1, 4'd0, ZERO);
        rst_n = 1'b1;
        cyc("rst_release_idle", OP_LOAD, 1'b0, 1'b1, 4'd0, ZERO);
        expect_perf(32'd0, 32'd0);
        run_lw("post_rst_lw");
        expect_perf(32'd5, 32'd1);
        cyc("final_fetch_wait", OP_LOAD, 1'b0, 1'b0, 4'd0, mk(1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 2'b00, 0));

        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port op, input, 7 bits: opcode of the instruction register.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completes the current request this cycle.
REQ-006 SHALL have outputs mem_req (1), mem_write (1), adr_src (1), ir_write (1), pc_write (1) and reg_write (1): datapath strobes.
REQ-007 SHALL have outputs alu_src_a (2), alu_src_b (2), result_src (2), alu_op (2) and imm_src (2): datapath selects; alu_op feeds the ALU decoder.
REQ-008 SHALL have outputs illegal_instr (1), a one-cycle pulse, and state_o (4), which exposes the state encoding.

Function
REQ-009 SHALL implement a Moore FSM with these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10.
REQ-010 Unlisted strobes SHALL be 0 in every state, and unlisted selects SHALL be 00.
REQ-011 FETCH SHALL drive mem_req=1 and adr_src=0, and hold until mem_ready=1.
REQ-012 In the FETCH cycle where mem_ready=1, the block SHALL drive ir_write=1, pc_write=1, alu_src_b=10 and result_src=10, then go to DECODE.
REQ-013 DECODE SHALL drive alu_src_a=01 and alu_src_b=01 to compute the branch target.
REQ-014 DECODE SHALL branch on op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ.
REQ-015 Any other op in DECODE SHALL pulse illegal_instr and go to FETCH.
REQ-016 MEMADR SHALL drive alu_src_a=10 and alu_src_b=01, then go to MEMREAD if op=0000011, else to MEMWRITE.
REQ-017 MEMREAD SHALL drive mem_req=1 and adr_src=1, and hold until mem_ready=1, then go to MEMWB.
REQ-018 MEMWB SHALL drive result_src=01 and reg_write=1, then go to FETCH.
REQ-019 MEMWRITE SHALL drive mem_req=1, mem_write=1 and adr_src=1, and hold until mem_ready=1, then go to FETCH.
REQ-020 EXECR SHALL drive alu_src_a=10 and alu_op=10, then go to ALUWB.
REQ-021 EXECI SHALL drive alu_src_a=10, alu_src_b=01 and alu_op=10, then go to ALUWB.
REQ-022 ALUWB SHALL drive reg_write=1 with result_src=00, then go to FETCH.
REQ-023 JAL SHALL drive alu_src_a=01, alu_src_b=10 and pc_write=1, then go to ALUWB.
REQ-024 BEQ SHALL drive alu_src_a=10 and alu_op=01, drive pc_write=zero, then go to FETCH.
REQ-025 imm_src SHALL be combinational from op in every state: 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; otherwise 00.
REQ-026 Latency SHALL be the following cycle counts with mem_ready tied to 1: lw 5, sw 4, R/I 4, jal 4, beq 3; each cycle of mem_ready=0 SHALL add one cycle.
REQ-027 A mem_ready pulse outside FETCH, MEMREAD or MEMWRITE SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL force FETCH immediately, including mid-instruction.
REQ-029 During reset all strobes SHALL be 0, all selects 00 and illegal_instr 0; mem_req SHALL rise on the first clock edge after rst_n deasserts.

Configuration
REQ-030 With MC_CTRL_PERF_EN defined, the block SHALL add outputs cycle_cnt (32) and instret_cnt (32), both reset to 0.
REQ-031 cycle_cnt SHALL increment every cycle out of reset.
REQ-032 instret_cnt SHALL increment on each entry to FETCH, except the entry from an illegal DECODE.
REQ-033 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-034 Without MC_CTRL_PERF_EN, those ports and their logic SHALL be absent.

Structure
REQ-035 The state enum, the opcode constants and the alu_op encodings (00 ADD, 01 SUB, 10 funct-decode) SHALL live in the shared package mc_pkg.
REQ-036 The perf counters SHALL be an optional sub-module, mc_perf_counters.

Verification
REQ-037 The bench SHALL show: lw (op=0000011) with mem_ready=1 -> states 0,1,2,3,4, with reg_write=1 and result_src=01 in cycle 5.
REQ-038 The bench SHALL show: sw with mem_ready held 0 for 3 cycles in MEMWRITE -> state 5 held 4 cycles, mem_write=1 throughout, then FETCH.
REQ-039 The bench SHALL show: beq with zero=1 -> pc_write=1 in state 10; with zero=0 -> pc_write=0; both return to FETCH.
REQ-040 The bench SHALL show: op=0000000 -> illegal_instr=1 for one cycle in DECODE, next state 0, and instret_cnt unchanged.
REQ-041 The bench SHALL show: rst_n pulsed low in MEMREAD -> state_o=0 asynchronously, all strobes 0, and normal fetch after release.
REQ-042 The bench SHALL show, with MC_CTRL_PERF_EN: 10 back-to-back R-type instructions -> instret_cnt=10 and cycle_cnt=40.
